// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  // Responder sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACCESS  = 2'd2,
    RESPOND = 2'd3
  } state_e;

  // Width of the wait-state down-counter (covers 0..15 wait states)
  localparam int unsigned CNT_W = 4;

  // Byte address to word index shift
  localparam int unsigned ADDR_OFFSET = 2;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word storage with byte write enables and registered read data
module dmem_array #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // One access per enabled cycle: stores update enabled bytes and return zero, loads capture the word
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
        rdata_q <= '0;
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - valid/ready data-memory responder with wait states; byte enables under DMEM_BYTE_EN
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  req_be_i,
`endif
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rdata_ok_q, rdata_ok_d;

  logic             acc_err;
  logic             acc_en;
  logic [31:0]      arr_rdata;

`ifdef DMEM_BYTE_EN
  logic [3:0] be_d;
`else
  assign be_q = 4'hF;
`endif

  // Misaligned or beyond the array (full 32-bit compare, so no aliasing of high addresses)
  assign acc_err = (addr_q[1:0] != 2'b00) || ((addr_q >> ADDR_OFFSET) >= 32'(DEPTH));
  assign acc_en  = (state_q == ACCESS) && !acc_err;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i  (clk_i),
    .en_i   (acc_en),
    .we_i   (write_q),
    .be_i   (be_q),
    .idx_i  (addr_q[ADDR_OFFSET +: IDX_W]),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata)
  );

  // State, latched request and registered response flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_ok_q  <= 1'b0;
`ifdef DMEM_BYTE_EN
      be_q        <= 4'h0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_ok_q  <= rdata_ok_d;
`ifdef DMEM_BYTE_EN
      be_q        <= be_d;
`endif
    end
  end

  // Next-state and next-output decode; output registers are updated one edge ahead of the state they describe
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rdata_ok_d  = rdata_ok_q;
`ifdef DMEM_BYTE_EN
    be_d        = be_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          write_d     = req_write_i;
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
`ifdef DMEM_BYTE_EN
          be_d        = req_be_i;
`endif
          req_ready_d = 1'b0;
          cnt_d       = CNT_LOAD;
          state_d     = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACCESS: begin
        state_d     = RESPOND;
        rsp_valid_d = 1'b1;
        rsp_err_d   = acc_err;
        rdata_ok_d  = !acc_err && !write_q;
      end
      RESPOND: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rdata_ok_d  = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rdata_ok_q ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (optionally with DMEM_BYTE_EN)
module tb_dmem_responder;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned WC     = 2;
  localparam int unsigned DEPTH0 = 16;
`ifdef DMEM_BYTE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        req_valid0, req_ready0, req_write0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
  logic [3:0]  req_be0;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
`ifdef DMEM_BYTE_EN
    .req_be_i(req_be),
`endif
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  dmem_responder #(.DEPTH(DEPTH0), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_write_i(req_write0),
    .req_addr_i(req_addr0), .req_wdata_i(req_wdata0),
`ifdef DMEM_BYTE_EN
    .req_be_i(req_be0),
`endif
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference memory: byte contents plus a per-byte "has been written" flag
  logic [7:0] mbytes [DEPTH*4];
  bit         mknown [DEPTH*4];

  function automatic bit exp_err_f(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  // One transaction on the main DUT: accept, measure latency, optionally hold the response, handshake
  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input int hold, input string tag, output logic [31:0] rd, output bit er);
    int lat;
    @(negedge clk);
    chk({tag, " req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, WC + 1);
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, rsp_valid, 1);
      chk({tag, " hold_rdata"}, rsp_rdata, rd);
      chk({tag, " hold_err"}, rsp_err, er);
      chk({tag, " hold_req_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " post_req_ready"}, req_ready, 1);
    chk({tag, " post_rsp_valid"}, rsp_valid, 0);
  endtask

  // Transaction checked against the reference memory, which it then updates
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input int hold, input string tag, output logic [31:0] rd, output bit er);
    bit          e;
    logic [31:0] em, mask;
    logic [3:0]  beff;
    int          base;
    e    = exp_err_f(a);
    beff = BE_EN ? be : 4'hF;
    em   = '0;
    mask = '0;
    base = int'(a / 4) * 4;
    if (!e && !w) begin
      for (int b = 0; b < 4; b++) begin
        em[8*b +: 8] = mbytes[base + b];
        if (mknown[base + b]) mask[8*b +: 8] = 8'hFF;
      end
    end
    do_req(w, a, d, be, hold, tag, rd, er);
    chk({tag, " err"}, er, e);
    if (w || e) chk({tag, " rdata_zero"}, rd, 0);
    else if (mask != 0) chk({tag, " rdata_model"}, rd & mask, em & mask);
    if (w && !e) begin
      for (int b = 0; b < 4; b++) begin
        if (beff[b]) begin
          mbytes[base + b] = d[8*b +: 8];
          mknown[base + b] = 1'b1;
        end
      end
    end
  endtask

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] rd;
  bit          er;

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 4'hF; rsp_ready = 0;
    req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 4'hF; rsp_ready0 = 1;
    for (int i = 0; i < DEPTH*4; i++) begin mbytes[i] = 8'h00; mknown[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", req_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_err", rsp_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Zero wait states, response always taken: accept every 3rd cycle, respond 1 cycle later
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("w0 ready c%0d", c), req_ready0, (c % 3 == 0));
      chk($sformatf("w0 valid c%0d", c), rsp_valid0, (c % 3 == 2));
      if (c % 3 == 2) begin
        case (c / 3)
          2:       chk("w0 load0 rdata", rsp_rdata0, 32'hA5A5_0001);
          3:       chk("w0 load4 rdata", rsp_rdata0, 32'h5A5A_0002);
          default: chk($sformatf("w0 store rdata c%0d", c), rsp_rdata0, 0);
        endcase
        chk($sformatf("w0 err c%0d", c), rsp_err0, 0);
      end
      if (c % 3 == 0) begin
        req_valid0 = 1'b1;
        case (c / 3)
          0: begin req_write0 = 1; req_addr0 = 32'h0; req_wdata0 = 32'hA5A5_0001; end
          1: begin req_write0 = 1; req_addr0 = 32'h4; req_wdata0 = 32'h5A5A_0002; end
          2: begin req_write0 = 0; req_addr0 = 32'h0; req_wdata0 = 32'h0; end
          default: begin req_write0 = 0; req_addr0 = 32'h4; req_wdata0 = 32'h0; end
        endcase
      end
      if (c == 10) req_valid0 = 1'b0;
    end

    // Directed vectors with fixed expectations
    tbl.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 0, 32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'hF, 0, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'(4*DEPTH),  32'h0,         4'hF, 0, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 0, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 0, 32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 32'(4*DEPTH),  32'h1234_5678, 4'hF, 0, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 32'h0000_0002, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'hF, 0, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 5, 32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'hF, 5, 32'h0, 1'b1});
`ifdef DMEM_BYTE_EN
    tbl.push_back('{1'b1, 32'h0000_0030, 32'hAABB_CCDD, 4'hF, 0, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0030, 32'h0000_0011, 4'h1, 0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0030, 32'h0,         4'h0, 0, 32'hAABB_CC11, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0030, 32'h0,         4'h5, 0, 32'hAABB_CC11, 1'b0});
`endif
    foreach (tbl[i]) begin
      txn(tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].hold, $sformatf("vec%0d", i), rd, er);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d err_tbl", i), er, tbl[i].exp_err);
    end

    // Reset during the wait states of a store: the store must never land
    txn(1'b1, 32'h20, 32'h1111_1111, 4'hF, 0, "rst_pre", rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h2222_2222; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid req_ready_busy", req_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid req_ready", req_ready, 1);
    chk("rst_mid rsp_valid", rsp_valid, 0);
    chk("rst_mid rsp_rdata", rsp_rdata, 0);
    chk("rst_mid rsp_err", rsp_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, "rst_post", rd, er);
    chk("rst_post rdata_fixed", rd, 32'h1111_1111);

    // Random traffic against the reference memory
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int          kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else if (kind == 1) a = 32'(4*DEPTH) + 32'($urandom_range(0, 1000)) * 4;
      else if (kind == 2) a = $urandom | 32'h8000_0000;
      else                a = 32'($urandom_range(0, 15)) * 4;
      txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), $sformatf("rnd%0d", n), rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the processor's data-memory port: accepts one load or store request at a time over a valid/ready handshake, services it from an internal word array after a programmable number of wait states, and returns a response with read data or an error flag. It sits between the processor's load/store path (ALU result as address, register data as store data) and storage. It replaces the fixed single-cycle RAM, so multi-cycle memory timing can be modelled and verified.

## Interface
- DEPTH, 256: number of 32-bit words stored; must be a power of two, at least 4.
- WAIT_CYCLES, 2: wait states between request acceptance and the access; range 0–15.
- Clk  input  1  single clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Req_Valid  input  1  request present.
- Req_Ready  output  1  responder can accept a request this cycle.
- Req_Write  input  1  1 = store, 0 = load.
- Req_Addr  input  32  byte address.
- Req_Wdata  input  32  store data.
- Req_Be  input  4  byte enables; present only with DMEM_BYTE_EN.
- Rsp_Valid  output  1  response present.
- Rsp_Ready  input  1  requester takes the response.
- Rsp_Rdata  output  32  load data; 0 for stores and errors.
- Rsp_Err  output  1  request was misaligned or out of range.

## Operation
- States: IDLE, WAIT, ACCESS, RESPOND.
- IDLE: Req_Ready=1. When Req_Valid is high, the responder latches Write, Addr, Wdata and Be. It goes to WAIT with the counter loaded to WAIT_CYCLES-1, or to ACCESS if WAIT_CYCLES=0.
- WAIT: Req_Ready=0. Counter decrements each cycle. At 0 it goes to ACCESS.
- ACCESS: the responder checks the latched request and performs it in one cycle, then goes to RESPOND.
  - Error: Addr[1:0]!=0, or word index Addr>>2 >= DEPTH. An error sets the Err flag, writes nothing, and sets Rdata=0.
  - Store: writes Wdata to word Addr>>2 and sets Rdata=0.
  - Load: captures the array word into Rdata.
- RESPOND: Rsp_Valid=1. Rsp_Rdata and Rsp_Err hold steady until Rsp_Ready is high. On that handshake the responder returns to IDLE.
- Only one request is outstanding at a time. Req_Valid is ignored outside IDLE. Inputs need not be held after acceptance.
- Address compare uses the full 32 bits. There is no wrap-around: out-of-range addresses always produce an error.

## Timing
- Reset values: state IDLE, Req_Ready=1, Rsp_Valid=0, Rsp_Rdata=0, Rsp_Err=0, counter 0.
- Array contents are not reset and are undefined at power-up. Contents are retained across Rst.
- Latency: if a request is accepted at edge N, Rsp_Valid rises after edge N+WAIT_CYCLES+1.
- Throughput: at best one request per WAIT_CYCLES+3 cycles: accept, waits, access, response handshake, return to IDLE.
- Rst asserted mid-transaction: the responder returns to IDLE immediately and drops Rsp_Valid. A store that has not reached ACCESS is never written. A store whose ACCESS edge has already occurred stays written.
- Rsp_Ready high while Rsp_Valid is low has no effect.
- All outputs are driven from registers. There is no combinational path from any input to any output.

## Configuration
- DMEM_BYTE_EN defined:
  - The Req_Be port exists.
  - A store writes only the bytes whose enable bit is 1; Be=0000 is a legal no-op store with Err=0.
  - Loads ignore Be and return the full word.
- DMEM_BYTE_EN undefined:
  - The Req_Be port is absent.
  - Every store writes all four bytes.

## Structure
- dmem_pkg holds:
  - the state typedef: IDLE, WAIT, ACCESS, RESPOND;
  - the wait-counter width constant: 4 bits;
  - the address-offset constant for word indexing: 2.
- Sub-module dmem_array holds the storage: synchronous single-port word array with write enable, per-byte write enables (tied to 1111 without DMEM_BYTE_EN), and registered read data. The FSM, counter and error check stay in dmem_responder.

## Test plan
- Reset, then store 0xDEADBEEF to address 0x10, then load 0x10 -> each Rsp_Valid arrives exactly WAIT_CYCLES+1 cycles after acceptance. The load returns 0xDEADBEEF with Err=0.
- Load from address 0x13 (misaligned), then from 4*DEPTH -> Err=1 and Rdata=0 for both. A subsequent load of 0x10 still returns 0xDEADBEEF.
- Hold Rsp_Ready low for 5 cycles after Rsp_Valid -> Rsp_Valid, Rdata and Err are stable throughout, and Req_Ready stays 0 until one cycle after the handshake.
- Store 0x11111111 to 0x20, then assert Rst during WAIT of a second store of 0x22222222 to 0x20 -> outputs return to reset values. A load of 0x20 returns 0x11111111.
- With DMEM_BYTE_EN defined: store 0xAABBCCDD to 0x30 with Be=1111, then 0x00000011 with Be=0001 -> a load returns 0xAABBCC11. A store with Be=0000 leaves the word unchanged.
- With WAIT_CYCLES=0: back-to-back requests with Rsp_Ready tied high -> each response arrives 1 cycle after acceptance, and a new request is accepted every 3 cycles.
